// File: rtl/sr_cmd_gen_if.sv
// Button-to-latch command bundle: raw buttons in, clean s/r/en commands out.
// Latency: none (wiring only).
// Backpressure: none; the latch consumes every command strobe.
interface sr_cmd_gen_if;
   logic set_btn;
   logic reset_btn;
   logic s;
   logic r;
   logic en;
   logic busy;
   logic conflict;

   // Board/pin side: drives the buttons and watches the latch commands.
   modport master (
      output set_btn, reset_btn,
      input  s, r, en, busy, conflict
   );

   // Command generator side.
   modport slave (
      input  set_btn, reset_btn,
      output s, r, en, busy, conflict
   );
endinterface

// File: rtl/sr_cmd_gen.sv
// Debounces set/reset buttons into registered s/r/en pulses for the SR latch, never s=r=1.
// Latency: button first sampled at edge k -> en high after edge k+DB_CYCLES+2, for PULSE_CYCLES.
// Backpressure: none; presses are ignored while busy, one command per press, no auto-repeat.
module sr_cmd_gen #(
   parameter int DB_CYCLES    = 16,
   parameter int PULSE_CYCLES = 2,
   parameter int CNT_W        = 8
) (
   input  logic         clk,
   input  logic         rst,
   sr_cmd_gen_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, DRIVE, WAIT_REL} state_t;

   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [1:0]       cand, cand_nx;
   logic [1:0]       code;
   logic             set_meta, set_sync, reset_meta, reset_sync;
   logic             s_q, r_q, en_q, busy_q, conflict_q;
   logic             s_nx, r_nx, en_nx, conflict_nx;

   assign code = {set_sync, reset_sync};

   // Two-flop synchronizers bring the asynchronous buttons into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         set_meta   <= 1'b0;
         set_sync   <= 1'b0;
         reset_meta <= 1'b0;
         reset_sync <= 1'b0;
      end else begin
         set_meta   <= bus.set_btn;
         set_sync   <= set_meta;
         reset_meta <= bus.reset_btn;
         reset_sync <= reset_meta;
      end
   end

   // State, counter and registered command outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         cand       <= 2'b00;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         cand       <= cand_nx;
         s_q        <= s_nx;
         r_q        <= r_nx;
         en_q       <= en_nx;
         busy_q     <= (state_nx != IDLE);
         conflict_q <= conflict_nx;
      end
   end

   // Next-state logic; commands default low so s/r can only be set while en is driven.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      cand_nx     = cand;
      s_nx        = 1'b0;
      r_nx        = 1'b0;
      en_nx       = 1'b0;
      conflict_nx = 1'b0;
      case (state)
         IDLE: begin
            if (code != 2'b00) begin
               cand_nx  = code;
               cnt_nx   = '0;
               state_nx = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (code != cand) begin
               // Any change during qualification is treated as bounce.
               cnt_nx   = '0;
               state_nx = IDLE;
            end else if (cnt == DB_LAST) begin
               cnt_nx = '0;
               if (cand == 2'b11) begin
                  // Both buttons held: flag it and issue no command.
                  conflict_nx = 1'b1;
                  state_nx    = WAIT_REL;
               end else begin
                  en_nx    = 1'b1;
                  s_nx     = cand[1];
                  r_nx     = cand[0];
                  state_nx = DRIVE;
               end
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         DRIVE: begin
            if (cnt == PULSE_LAST) begin
               cnt_nx   = '0;
               state_nx = WAIT_REL;
            end else begin
               en_nx  = en_q;
               s_nx   = s_q;
               r_nx   = r_q;
               cnt_nx = cnt + CNT_ONE;
            end
         end
         WAIT_REL: begin
            // Require a full debounce window of released buttons before re-arming.
            if (code == 2'b00) begin
               if (cnt == DB_LAST) begin
                  cnt_nx   = '0;
                  state_nx = IDLE;
               end else begin
                  cnt_nx = cnt + CNT_ONE;
               end
            end else begin
               cnt_nx = '0;
            end
         end
         default: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.s        = s_q;
   assign bus.r        = r_q;
   assign bus.en       = en_q;
   assign bus.busy     = busy_q;
   assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen with a sample-counting reference model.
// Latency: model tracks the two-sample synchronizer delay and press/release windows.
// Backpressure: n/a.
module tb_sr_cmd_gen;
   localparam int DB = 4;
   localparam int PL = 2;

   localparam int M_IDLE  = 0;
   localparam int M_QUAL  = 1;
   localparam int M_PULSE = 2;
   localparam int M_HOLD  = 3;

   logic clk = 1'b0;
   logic rst;

   sr_cmd_gen_if bus_if ();

   sr_cmd_gen #(
      .DB_CYCLES   (DB),
      .PULSE_CYCLES(PL),
      .CNT_W       (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: counts samples of the delayed button code.
   int         m_mode, m_run, m_left, m_rel;
   logic [1:0] m_p1, m_p2, m_cand, m_code;
   logic       m_en, m_s, m_r, m_conflict, m_busy;

   task automatic model_reset();
      m_mode = M_IDLE; m_run = 0; m_left = 0; m_rel = 0;
      m_p1 = 2'b00; m_p2 = 2'b00; m_cand = 2'b00; m_code = 2'b00;
      m_en = 1'b0; m_s = 1'b0; m_r = 1'b0; m_conflict = 1'b0; m_busy = 1'b0;
   endtask

   task automatic model_step();
      m_code = m_p2;
      m_conflict = 1'b0;
      case (m_mode)
         M_IDLE: if (m_code != 2'b00) begin
            m_cand = m_code;
            m_run  = 1;
            m_mode = M_QUAL;
         end
         M_QUAL: if (m_code != m_cand) m_mode = M_IDLE;
         else begin
            m_run++;
            if (m_run == DB + 1) begin
               if (m_cand == 2'b11) begin
                  m_conflict = 1'b1;
                  m_rel      = 0;
                  m_mode     = M_HOLD;
               end else begin
                  m_left = PL;
                  m_mode = M_PULSE;
               end
            end
         end
         M_PULSE: begin
            m_left--;
            if (m_left == 0) begin
               m_rel  = 0;
               m_mode = M_HOLD;
            end
         end
         default: begin
            if (m_code == 2'b00) m_rel++;
            else m_rel = 0;
            if (m_rel == DB) m_mode = M_IDLE;
         end
      endcase
      m_p2   = m_p1;
      m_p1   = {bus_if.set_btn, bus_if.reset_btn};
      m_en   = (m_mode == M_PULSE);
      m_s    = m_en & m_cand[1];
      m_r    = m_en & m_cand[0];
      m_busy = (m_mode != M_IDLE);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_step();
   end

   // Per-scenario observations of the DUT.
   int   rises, en_cycles, conf_cycles, first_en_cyc, conf_cyc, busy_fall_cyc;
   logic first_s, first_r, prev_en, prev_busy;

   task automatic clr();
      rises = 0; en_cycles = 0; conf_cycles = 0;
      first_en_cyc = -1; conf_cyc = -1; busy_fall_cyc = -1;
      first_s = 1'b0; first_r = 1'b0;
   endtask

   task automatic monitor();
      chk1("cmp_en", bus_if.en, m_en);
      chk1("cmp_s", bus_if.s, m_s);
      chk1("cmp_r", bus_if.r, m_r);
      chk1("cmp_busy", bus_if.busy, m_busy);
      chk1("cmp_conflict", bus_if.conflict, m_conflict);
      chk1("cmp_no_sr", bus_if.s & bus_if.r, 1'b0);
      if (bus_if.en && !prev_en) begin
         if (rises == 0) begin
            first_en_cyc = cyc;
            first_s      = bus_if.s;
            first_r      = bus_if.r;
         end
         rises++;
      end
      if (bus_if.en) en_cycles++;
      if (bus_if.conflict) begin
         conf_cycles++;
         conf_cyc = cyc;
      end
      if (prev_busy && !bus_if.busy) busy_fall_cyc = cyc;
      prev_en   = bus_if.en;
      prev_busy = bus_if.busy;
   endtask

   always @(negedge clk) monitor();

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   int k, j, h;

   initial begin
      prev_en = 1'b0;
      prev_busy = 1'b0;
      clr();
      bus_if.set_btn   = 1'b0;
      bus_if.reset_btn = 1'b0;
      rst = 1'b1;
      step(3);
      chk1("reset_en", bus_if.en, 1'b0);
      chk1("reset_busy", bus_if.busy, 1'b0);
      rst = 1'b0;
      step(2);

      // 1: asynchronous reset while a held set press is qualifying
      bus_if.set_btn = 1'b1;
      step(4);
      chk1("t1_busy_before_rst", bus_if.busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("t1_async_s", bus_if.s, 1'b0);
      chk1("t1_async_r", bus_if.r, 1'b0);
      chk1("t1_async_en", bus_if.en, 1'b0);
      chk1("t1_async_busy", bus_if.busy, 1'b0);
      chk1("t1_async_conflict", bus_if.conflict, 1'b0);
      bus_if.set_btn = 1'b0;
      step(2);
      rst = 1'b0;
      step(8);

      // 2: clean set press
      clr();
      bus_if.set_btn = 1'b1;
      k = cyc + 1;
      step(20);
      bus_if.set_btn = 1'b0;
      j = cyc + 1;
      step(12);
      chkn("t2_pulses", rises, 1);
      chkn("t2_en_cycles", en_cycles, 2);
      chkn("t2_en_rise_cycle", first_en_cyc, k + 6);
      chk1("t2_s", first_s, 1'b1);
      chk1("t2_r", first_r, 1'b0);
      chkn("t2_busy_fall_cycle", busy_fall_cyc, j + 5);

      // 3: bouncing reset button, then stable
      clr();
      bus_if.reset_btn = 1'b1; step(1);
      bus_if.reset_btn = 1'b0; step(1);
      bus_if.reset_btn = 1'b1; step(1);
      bus_if.reset_btn = 1'b0; step(1);
      bus_if.reset_btn = 1'b1;
      h = cyc + 1;
      step(15);
      bus_if.reset_btn = 1'b0;
      step(12);
      chkn("t3_pulses", rises, 1);
      chkn("t3_en_cycles", en_cycles, 2);
      chkn("t3_en_rise_cycle", first_en_cyc, h + 6);
      chk1("t3_s", first_s, 1'b0);
      chk1("t3_r", first_r, 1'b1);

      // 4: both buttons together
      clr();
      bus_if.set_btn   = 1'b1;
      bus_if.reset_btn = 1'b1;
      k = cyc + 1;
      step(10);
      bus_if.set_btn   = 1'b0;
      bus_if.reset_btn = 1'b0;
      j = cyc + 1;
      step(12);
      chkn("t4_conflict_cycles", conf_cycles, 1);
      chkn("t4_conflict_cycle", conf_cyc, k + 6);
      chkn("t4_pulses", rises, 0);
      chkn("t4_busy_fall_cycle", busy_fall_cyc, j + 5);

      // 5: long hold gives one pulse; re-press after release gives another
      clr();
      bus_if.set_btn = 1'b1;
      step(100);
      bus_if.set_btn = 1'b0;
      step(6);
      chkn("t5_pulses_after_hold", rises, 1);
      bus_if.set_btn = 1'b1;
      step(15);
      bus_if.set_btn = 1'b0;
      step(12);
      chkn("t5_pulses", rises, 2);
      chkn("t5_en_cycles", en_cycles, 4);

      // 6a: short glitch is rejected
      clr();
      bus_if.set_btn = 1'b1;
      step(2);
      bus_if.set_btn = 1'b0;
      step(10);
      chkn("t6_glitch_pulses", rises, 0);

      // 6b: reset during DRIVE, button still held afterwards
      clr();
      bus_if.set_btn = 1'b1;
      step(7);
      chk1("t6_en_in_drive", bus_if.en, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("t6_async_en", bus_if.en, 1'b0);
      chk1("t6_async_s", bus_if.s, 1'b0);
      chk1("t6_async_busy", bus_if.busy, 1'b0);
      step(1);
      rst = 1'b0;
      clr();
      k = cyc + 1;
      step(10);
      chkn("t6_pulses_after_rst", rises, 1);
      chkn("t6_en_rise_cycle", first_en_cyc, k + 6);
      bus_if.set_btn = 1'b0;
      step(12);
      chkn("t6_en_cycles", en_cycles, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
